comparator_8bit: RTL and testbench

COMPARATOR_8BIT -- requirements
Module: comparator_8bit

---
 rtl/comparator_8bit.sv | 87 ++++++++
 tb/tb_comparator_8bit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_8bit.sv
// -----------------------------------------------------------------------------
// comparator_8bit
//
// Registered magnitude comparator. Each rising clock edge samples operands a
// and b and updates three mutually exclusive flags (greater, less, equal)
// one cycle later. The SIGNED parameter selects unsigned or two's-complement
// ordering. Equality is always bitwise identity.
//
// Parameters
//   WIDTH   operand width in bits (default 8)
//   SIGNED  0 = unsigned ordering, 1 = two's-complement ordering
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   a_gt_b     out  1      registered A > B
//   a_lt_b     out  1      registered A < B
//   a_eq_b     out  1      registered A == B
//   out_valid  out  1      flags reflect a sampled operand pair
// -----------------------------------------------------------------------------
module comparator_8bit #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             out_valid
);

  // Inverting the sign bit of both operands maps two's-complement order onto
  // unsigned order, so a single unsigned compare covers both modes.
  function automatic logic is_less(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             sgn
  );
    logic [WIDTH-1:0] msb_flip;
    msb_flip = {sgn, {(WIDTH-1){1'b0}}};
    return ((x ^ msb_flip) < (y ^ msb_flip));
  endfunction

  logic gt_d, lt_d, eq_d, valid_d;
  logic gt_q, lt_q, eq_q, valid_q;

  // Next-state flags from the current operand pair.
  always_comb begin
    gt_d    = 1'b0;
    lt_d    = 1'b0;
    eq_d    = 1'b0;
    valid_d = 1'b1;
    if (a == b) begin
      eq_d = 1'b1;
    end else if (is_less(a, b, SIGNED)) begin
      lt_d = 1'b1;
    end else begin
      gt_d = 1'b1;
    end
  end

  // Flag and valid registers; reset takes priority over sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      valid_q <= valid_d;
    end
  end

  assign a_gt_b    = gt_q;
  assign a_lt_b    = lt_q;
  assign a_eq_b    = eq_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_comparator_8bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_8bit
//
// Drives one operand stream into an unsigned and a signed comparator instance.
// Expected outputs {out_valid, gt, lt, eq} are pushed to per-instance queues
// when stimulus is applied and popped when the following edge produces output.
// -----------------------------------------------------------------------------
module tb_comparator_8bit;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       gt_u, lt_u, eq_u, vld_u;
  logic       gt_s, lt_s, eq_s, vld_s;

  logic [3:0] q_u[$];
  logic [3:0] q_s[$];
  int         n_checks;
  int         n_pass;

  comparator_8bit #(.WIDTH(8), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .a_gt_b(gt_u), .a_lt_b(lt_u), .a_eq_b(eq_u), .out_valid(vld_u)
  );

  comparator_8bit #(.WIDTH(8), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .a_gt_b(gt_s), .a_lt_b(lt_s), .a_eq_b(eq_s), .out_valid(vld_s)
  );

  // Clock that can be frozen low.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference: integer compare after explicit zero- or sign-extension.
  function automatic logic [3:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sgn);
    int ia, ib;
    if (sgn) begin
      ia = int'($signed(av));
      ib = int'($signed(bv));
    end else begin
      ia = int'(av);
      ib = int'(bv);
    end
    return {1'b1, (ia > ib), (ia < ib), (ia == ib)};
  endfunction

  // Apply one operand pair (and rst) before an edge, queue the expectations,
  // then return just after that edge.
  task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic r);
    @(negedge clk);
    a   = av;
    b   = bv;
    rst = r;
    if (r) begin
      q_u.push_back(4'b0000);
      q_s.push_back(4'b0000);
    end else begin
      q_u.push_back(model(av, bv, 1'b0));
      q_s.push_back(model(av, bv, 1'b1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] eu, es;
    drive(8'd150, 8'd100, 1'b1);
    drive(8'd150, 8'd100, 1'b1);
    for (int i = 0; i < 2; i++) begin
      eu = q_u.pop_front();
      es = q_s.pop_front();
    end
    n_checks++;
    if ({vld_u, gt_u, lt_u, eq_u} !== eu)
      $display("FAIL reset_u: got %b expected %b", {vld_u, gt_u, lt_u, eq_u}, eu);
    else n_pass++;
    n_checks++;
    if ({vld_s, gt_s, lt_s, eq_s} !== es)
      $display("FAIL reset_s: got %b expected %b", {vld_s, gt_s, lt_s, eq_s}, es);
    else n_pass++;
  endtask

  task automatic test_release();
    logic [3:0] eu, es;
    drive(8'd150, 8'd100, 1'b0);
    eu = q_u.pop_front();
    es = q_s.pop_front();
    n_checks++;
    if ({vld_u, gt_u, lt_u, eq_u} !== eu)
      $display("FAIL release_u: got %b expected %b", {vld_u, gt_u, lt_u, eq_u}, eu);
    else n_pass++;
    n_checks++;
    if ({vld_s, gt_s, lt_s, eq_s} !== es)
      $display("FAIL release_s: got %b expected %b", {vld_s, gt_s, lt_s, eq_s}, es);
    else n_pass++;
  endtask

  // Directed pairs including the boundary values, applied back to back.
  task automatic test_directed();
    logic [7:0] ta[10] = '{8'd60, 8'd200, 8'd0, 8'd255, 8'd0, 8'd255, 8'h80, 8'hFF, 8'h7F, 8'd150};
    logic [7:0] tb[10] = '{8'd180, 8'd200, 8'd0, 8'd0, 8'd255, 8'd255, 8'h7F, 8'h00, 8'h80, 8'd100};
    logic [3:0] eu, es;
    for (int i = 0; i < 10; i++) begin
      drive(ta[i], tb[i], 1'b0);
      eu = q_u.pop_front();
      es = q_s.pop_front();
      n_checks++;
      if ({vld_u, gt_u, lt_u, eq_u} !== eu)
        $display("FAIL directed_u[%0d] a=%h b=%h: got %b expected %b", i, ta[i], tb[i], {vld_u, gt_u, lt_u, eq_u}, eu);
      else n_pass++;
      n_checks++;
      if ({vld_s, gt_s, lt_s, eq_s} !== es)
        $display("FAIL directed_s[%0d] a=%h b=%h: got %b expected %b", i, ta[i], tb[i], {vld_s, gt_s, lt_s, eq_s}, es);
      else n_pass++;
    end
  endtask

  // Operands change between edges; outputs must hold until the next edge.
  task automatic test_mid_cycle();
    logic [3:0] eu, es;
    drive(8'd10, 8'd20, 1'b0);
    eu = q_u.pop_front();
    es = q_s.pop_front();
    #1;
    a = 8'd250;
    b = 8'd5;
    #2;
    n_checks++;
    if ({vld_u, gt_u, lt_u, eq_u} !== eu)
      $display("FAIL midcycle_u: got %b expected %b", {vld_u, gt_u, lt_u, eq_u}, eu);
    else n_pass++;
    n_checks++;
    if ({vld_s, gt_s, lt_s, eq_s} !== es)
      $display("FAIL midcycle_s: got %b expected %b", {vld_s, gt_s, lt_s, eq_s}, es);
    else n_pass++;
  endtask

  // Reset asserted mid-stream clears on that edge; the first pair after
  // release appears on the following edge with valid set.
  task automatic test_mid_reset();
    logic [3:0] eu, es;
    logic [7:0] ra[3] = '{8'd9, 8'd150, 8'd3};
    logic [7:0] rb[3] = '{8'd9, 8'd100, 8'd200};
    logic       rr[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(ra[i], rb[i], rr[i]);
      eu = q_u.pop_front();
      es = q_s.pop_front();
      n_checks++;
      if ({vld_u, gt_u, lt_u, eq_u} !== eu)
        $display("FAIL midreset_u[%0d]: got %b expected %b", i, {vld_u, gt_u, lt_u, eq_u}, eu);
      else n_pass++;
      n_checks++;
      if ({vld_s, gt_s, lt_s, eq_s} !== es)
        $display("FAIL midreset_s[%0d]: got %b expected %b", i, {vld_s, gt_s, lt_s, eq_s}, es);
      else n_pass++;
    end
  endtask

  // With the clock frozen, rst and operand changes must not disturb outputs.
  task automatic test_clock_stopped();
    logic [3:0] eu, es;
    drive(8'd77, 8'd33, 1'b0);
    eu = q_u.pop_front();
    es = q_s.pop_front();
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    a   = 8'd1;
    b   = 8'd2;
    #30;
    n_checks++;
    if ({vld_u, gt_u, lt_u, eq_u} !== eu)
      $display("FAIL clkstop_u: got %b expected %b", {vld_u, gt_u, lt_u, eq_u}, eu);
    else n_pass++;
    n_checks++;
    if ({vld_s, gt_s, lt_s, eq_s} !== es)
      $display("FAIL clkstop_s: got %b expected %b", {vld_s, gt_s, lt_s, eq_s}, es);
    else n_pass++;
    rst    = 1'b0;
    clk_en = 1'b1;
  endtask

  // Random back-to-back pairs with the one-hot property checked each cycle.
  task automatic test_random();
    logic [3:0] eu, es;
    logic [7:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 8 == 0) ? ra : 8'($urandom_range(0, 255));
      drive(ra, rb, 1'b0);
      eu = q_u.pop_front();
      es = q_s.pop_front();
      n_checks++;
      if ({vld_u, gt_u, lt_u, eq_u} !== eu)
        $display("FAIL random_u[%0d] a=%h b=%h: got %b expected %b", i, ra, rb, {vld_u, gt_u, lt_u, eq_u}, eu);
      else n_pass++;
      n_checks++;
      if ({vld_s, gt_s, lt_s, eq_s} !== es)
        $display("FAIL random_s[%0d] a=%h b=%h: got %b expected %b", i, ra, rb, {vld_s, gt_s, lt_s, eq_s}, es);
      else n_pass++;
      n_checks++;
      if ($onehot({gt_u, lt_u, eq_u}) !== 1'b1 || $onehot({gt_s, lt_s, eq_s}) !== 1'b1)
        $display("FAIL onehot[%0d]: got u=%b s=%b expected one bit set in each", i, {gt_u, lt_u, eq_u}, {gt_s, lt_s, eq_s});
      else n_pass++;
    end
  endtask

  initial begin
    clk      = 1'b0;
    clk_en   = 1'b1;
    rst      = 1'b1;
    a        = 8'd0;
    b        = 8'd0;
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_release();
    test_directed();
    test_mid_cycle();
    test_mid_reset();
    test_clock_stopped();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
